// File: rtl/decode_issue_queue.sv
// Decode-stage issue queue: fetched {pc,instr} pairs are decoded on enqueue and
// held in a DEPTH-entry FIFO whose head drives the ID/EX control outputs.
module decode_issue_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [PC_W-1:0]            in_pc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [PC_W-1:0]            out_pc,
  output logic                       regwrite,
  output logic                       regdst,
  output logic                       alusrc,
  output logic                       branch,
  output logic                       memwrite,
  output logic                       memtoreg,
  output logic                       jump,
  output logic                       memen,
  output logic                       jal,
  output logic                       jr,
  output logic                       bal,
  output logic                       write_to_31,
  output logic                       hlwrite,
  output logic                       cp0we,
  output logic                       cp0read,
  output logic                       eret,
  output logic                       syscall,
  output logic                       brk,
  output logic                       ri,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int CTRL_W = 19;

  // Control bundle layout, MSB first:
  // regwrite regdst alusrc branch memwrite memtoreg jump | memen |
  // jal jr bal write_to_31 hlwrite | cp0we cp0read eret syscall brk | ri
  function automatic logic [CTRL_W-1:0] decode(input logic [31:0] instr);
    logic [5:0]        op;
    logic [5:0]        funct;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [CTRL_W-1:0] c;
    op    = instr[31:26];
    rs    = instr[25:21];
    rt    = instr[20:16];
    funct = instr[5:0];
    c     = 19'd0;
    case (op)
      6'h08, 6'h09, 6'h0A, 6'h0B,
      6'h0C, 6'h0D, 6'h0E, 6'h0F: c[18:12] = 7'b1010000;
      6'h04, 6'h05, 6'h06, 6'h07: c[18:12] = 7'b0001000;
      6'h02: c[18:12] = 7'b0000001;
      6'h03: begin
        c[18:12] = 7'b1000000;
        c[10]    = 1'b1;
        c[7]     = 1'b1;
      end
      6'h01: begin
        case (rt)
          5'h00, 5'h01: c[18:12] = 7'b0001000;
          5'h10, 5'h11: begin
            c[18:12] = 7'b1001000;
            c[8]     = 1'b1;
            c[7]     = 1'b1;
          end
          default: c[0] = 1'b1;
        endcase
      end
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
        c[18:12] = 7'b1010010;
        c[11]    = 1'b1;
      end
      6'h28, 6'h29, 6'h2B: begin
        c[18:12] = 7'b0010100;
        c[11]    = 1'b1;
      end
      6'h10: begin
        if (rs == 5'h00 && instr[10:0] == 11'd0) begin
          c[18:12] = 7'b1000000;
          c[4]     = 1'b1;
        end else if (rs == 5'h04 && instr[10:0] == 11'd0) begin
          c[5] = 1'b1;
        end else if (instr == 32'h42000018) begin
          c[3] = 1'b1;
        end else begin
          c[0] = 1'b1;
        end
      end
      6'h00: begin
        case (funct)
          6'h08: begin
            c[18:12] = 7'b0000001;
            c[9]     = 1'b1;
          end
          6'h09: begin
            c[18:12] = 7'b1100000;
            c[9]     = 1'b1;
          end
          6'h0C: c[2] = 1'b1;
          6'h0D: c[1] = 1'b1;
          6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: c[6] = 1'b1;
          6'h10, 6'h12: c[18:12] = 7'b1100000;
          6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
          6'h2A, 6'h2B: c[18:12] = 7'b1100000;
          default: c[0] = 1'b1;
        endcase
      end
      default: c[0] = 1'b1;
    endcase
    return c;
  endfunction

  logic [PC_W-1:0]   pc_mem    [DEPTH];
  logic [31:0]       instr_mem [DEPTH];
  logic [CTRL_W-1:0] ctrl_mem  [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count_r;
  logic              push;
  logic              pop;
  logic [CTRL_W-1:0] head_ctrl;

  assign count     = count_r;
  assign in_ready  = (count_r != CW'(DEPTH));
  assign out_valid = (count_r != CW'(0));
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_instr = instr_mem[rd_ptr];
  assign out_pc    = pc_mem[rd_ptr];

  // Pointer and occupancy update; reset and flush both empty the queue.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr  <= AW'(0);
      rd_ptr  <= AW'(0);
      count_r <= CW'(0);
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage: the word is decoded once, on the way in.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) begin
      pc_mem[wr_ptr]    <= in_pc;
      instr_mem[wr_ptr] <= in_instr;
      ctrl_mem[wr_ptr]  <= decode(in_instr);
    end
  end

  // Head control bundle, forced to zero while the queue is empty.
  always_comb begin
    head_ctrl = 19'd0;
    if (out_valid) begin
      head_ctrl = ctrl_mem[rd_ptr];
    end else begin
      head_ctrl = 19'd0;
    end
  end

  assign {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump,
          memen, jal, jr, bal, write_to_31, hlwrite,
          cp0we, cp0read, eret, syscall, brk, ri} = head_ctrl;

endmodule

// File: tb/tb_decode_issue_queue.sv
// Bench for decode_issue_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_decode_issue_queue;

  localparam int DEPTH = 4;
  localparam int PC_W  = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0]     in_instr, out_instr;
  logic [PC_W-1:0] in_pc, out_pc;
  logic            regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump;
  logic            memen, jal, jr, bal, write_to_31, hlwrite;
  logic            cp0we, cp0read, eret, syscall, brk, ri;
  logic [CW-1:0]   count;
  logic [18:0]     dut_ctrl;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t q[$];
  int compared   = 0;
  int mismatched = 0;
  logic [31:0] pc_seq = 32'h0040_0000;

  always #5 clk = ~clk;

  assign dut_ctrl = {regwrite, regdst, alusrc, branch, memwrite, memtoreg, jump,
                     memen, jal, jr, bal, write_to_31, hlwrite,
                     cp0we, cp0read, eret, syscall, brk, ri};

  decode_issue_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .regwrite(regwrite), .regdst(regdst), .alusrc(alusrc), .branch(branch),
    .memwrite(memwrite), .memtoreg(memtoreg), .jump(jump), .memen(memen),
    .jal(jal), .jr(jr), .bal(bal), .write_to_31(write_to_31), .hlwrite(hlwrite),
    .cp0we(cp0we), .cp0read(cp0read), .eret(eret), .syscall(syscall), .brk(brk),
    .ri(ri), .count(count)
  );

  // Reference decoder: classify the word, then raise the named controls.
  function automatic logic [18:0] ref_ctrl(input logic [31:0] w);
    logic [5:0] op, fn;
    logic [4:0] rs, rt;
    logic rw, rd, as, br, mw, mr, jp, me, jl, jrg, bl, w31, hl, cw, cr, er, sc, bk, rsv;
    op = w[31:26]; fn = w[5:0]; rs = w[25:21]; rt = w[20:16];
    {rw, rd, as, br, mw, mr, jp, me, jl, jrg, bl, w31, hl, cw, cr, er, sc, bk, rsv} = 19'd0;
    if (op inside {[6'h08:6'h0F]}) begin rw = 1'b1; as = 1'b1; end
    else if (op inside {[6'h04:6'h07]}) br = 1'b1;
    else if (op == 6'h02) jp = 1'b1;
    else if (op == 6'h03) begin rw = 1'b1; jl = 1'b1; w31 = 1'b1; end
    else if (op == 6'h01 && rt inside {5'h00, 5'h01}) br = 1'b1;
    else if (op == 6'h01 && rt inside {5'h10, 5'h11}) begin
      rw = 1'b1; br = 1'b1; bl = 1'b1; w31 = 1'b1;
    end
    else if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) begin
      rw = 1'b1; as = 1'b1; mr = 1'b1; me = 1'b1;
    end
    else if (op inside {6'h28, 6'h29, 6'h2B}) begin as = 1'b1; mw = 1'b1; me = 1'b1; end
    else if (op == 6'h10 && rs == 5'h00 && w[10:0] == 11'd0) begin rw = 1'b1; cr = 1'b1; end
    else if (op == 6'h10 && rs == 5'h04 && w[10:0] == 11'd0) cw = 1'b1;
    else if (w == 32'h4200_0018) er = 1'b1;
    else if (op == 6'h00 && fn == 6'h08) begin jp = 1'b1; jrg = 1'b1; end
    else if (op == 6'h00 && fn == 6'h09) begin rw = 1'b1; rd = 1'b1; jrg = 1'b1; end
    else if (op == 6'h00 && fn == 6'h0C) sc = 1'b1;
    else if (op == 6'h00 && fn == 6'h0D) bk = 1'b1;
    else if (op == 6'h00 && fn inside {6'h11, 6'h13, [6'h18:6'h1B]}) hl = 1'b1;
    else if (op == 6'h00 && fn inside {6'h10, 6'h12, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06,
                                       6'h07, [6'h20:6'h27], 6'h2A, 6'h2B}) begin
      rw = 1'b1; rd = 1'b1;
    end
    else rsv = 1'b1;
    return {rw, rd, as, br, mw, mr, jp, me, jl, jrg, bl, w31, hl, cw, cr, er, sc, bk, rsv};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("count", 64'(count), 64'(q.size()));
    chk("out_valid", 64'(out_valid), 64'(q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    if (q.size() != 0) begin
      chk("ctrl", 64'(dut_ctrl), 64'(ref_ctrl(q[0].instr)));
      chk("out_pc", 64'(out_pc), 64'(q[0].pc));
      chk("out_instr", 64'(out_instr), 64'(q[0].instr));
    end else begin
      chk("ctrl_empty", 64'(dut_ctrl), 64'd0);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, check on the falling edge.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                      input logic ordy, input logic fl, input logic rs);
    bit do_push, do_pop;
    rst = rs; flush = fl; in_valid = iv; in_instr = ins; in_pc = p; out_ready = ordy;
    @(posedge clk);
    do_push = iv && (q.size() < DEPTH);
    do_pop  = ordy && (q.size() != 0);
    if (rs || fl) begin
      q.delete();
    end else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back('{pc: p, instr: ins});
    end
    @(negedge clk);
    check_all();
  endtask

  function automatic logic [31:0] gen_instr();
    logic [31:0] r;
    logic [5:0]  ops [12];
    r = $urandom;
    ops = '{6'h08, 6'h0F, 6'h04, 6'h07, 6'h02, 6'h03, 6'h20, 6'h25, 6'h2B, 6'h28, 6'h01, 6'h00};
    case ($urandom_range(0, 6))
      0: return r;
      1, 2: return {ops[$urandom_range(0, 11)], r[25:0]};
      3: return {6'h00, r[25:6], 6'($urandom_range(0, 63))};
      4: return {6'h01, r[25:21], 5'($urandom_range(0, 19)), r[15:0]};
      5: return {6'h10, 5'h00, r[20:11], 11'd0};
      default: begin
        case ($urandom_range(0, 2))
          0: return {6'h10, 5'h04, r[20:11], 11'd0};
          1: return 32'h4200_0018;
          default: return {6'h10, r[25:0]};
        endcase
      end
    endcase
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = 32'd0; in_pc = 32'd0;
    @(negedge clk);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    // 1: three pushes then reset
    for (int i = 0; i < 3; i++) step(1'b1, 32'h2408_0000 + 32'(i), 32'h100 + 32'(4*i), 1'b0, 1'b0, 1'b0);
    chk("t1_count3", 64'(count), 64'd3);
    step(1'b1, 32'h2408_0009, 32'h200, 1'b1, 1'b0, 1'b1);
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_valid", 64'(out_valid), 64'd0);
    chk("t1_ready", 64'(in_ready), 64'd1);
    chk("t1_ctrl", 64'(dut_ctrl), 64'd0);

    // 2: LW into an empty queue
    step(1'b1, 32'h8C82_0004, 32'hBFC0_0000, 1'b0, 1'b0, 1'b0);
    chk("t2_valid", 64'(out_valid), 64'd1);
    chk("t2_ctrl", 64'(dut_ctrl), 64'(19'b1010010_1_00000_00000_0));
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // 3: fill past capacity with EX stalled, then drain in order
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 32'h0000_0020 + 32'(i << 11), 32'h300 + 32'(4*i), 1'b0, 1'b0, 1'b0);
      if (i == 3) chk("t3_full", 64'(in_ready), 64'd0);
    end
    chk("t3_held", 64'(count), 64'(DEPTH));
    step(1'b1, 32'h0000_2020, 32'h310, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // 4: flush drops the queue and the same-cycle push
    step(1'b1, 32'h3421_0001, 32'h400, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3421_0002, 32'h404, 1'b0, 1'b0, 1'b0);
    step(1'b1, 32'h3421_0003, 32'h408, 1'b1, 1'b1, 1'b0);
    chk("t4_count", 64'(count), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd0);

    // 5: decode sweep, each word reaching the head right after its push
    step(1'b1, 32'h0411_0003, 32'h500, 1'b1, 1'b0, 1'b0);
    chk("t5_bgezal", 64'(dut_ctrl), 64'(19'b1001000_0_00110_00000_0));
    step(1'b1, 32'h4200_0018, 32'h504, 1'b1, 1'b0, 1'b0);
    chk("t5_eret", 64'(dut_ctrl), 64'(19'b0000000_0_00000_00100_0));
    step(1'b1, 32'h0000_000D, 32'h508, 1'b1, 1'b0, 1'b0);
    chk("t5_brk", 64'(dut_ctrl), 64'(19'b0000000_0_00000_00001_0));
    step(1'b1, 32'hFC00_0000, 32'h50C, 1'b1, 1'b0, 1'b0);
    chk("t5_ri", 64'(dut_ctrl), 64'd1);
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0);

    // 6: steady push&pop at occupancy 1 across pointer wrap
    step(1'b1, 32'h2402_0000, 32'h600, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 2*DEPTH+1; i++) begin
      step(1'b1, 32'h2402_0000 + 32'(i), 32'h600 + 32'(4*i), 1'b1, 1'b0, 1'b0);
      chk("t6_count", 64'(count), 64'd1);
    end

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      pc_seq = pc_seq + 32'd4;
      step(($urandom_range(0, 3) != 0), gen_instr(), pc_seq,
           ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0),
           ($urandom_range(0, 96) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
